// File: rtl/fpga_ram_arbiter.sv
// ============================================================================
// Module   : fpga_ram_arbiter
// Brief    : Two-port round-robin arbiter with bounded locking for a RAM256
//            style macro (byte write enables, registered read address).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpga_ram_arbiter #(
    parameter int AW       = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [3:0]    we0,
    input  logic [3:0]    we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          ram_en,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_di,
    output logic [3:0]    ram_we,
    input  logic [31:0]   ram_do
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    localparam int            C_CW       = 8;
    localparam logic [C_CW-1:0] C_MAX_LOCK = C_CW'(MAX_LOCK);

    owner_t          r_owner;
    owner_t          w_owner_nxt;
    logic            r_last;        // 1: port1 was the most recent winner
    logic [C_CW-1:0] r_lock_cnt;
    logic [C_CW-1:0] w_lock_cnt_nxt;
    logic [AW-1:0]   r_ram_a;
    logic            r_rvalid0;
    logic            r_rvalid1;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_own0_hold;
    logic            w_own1_hold;
    logic            w_cap;

    // Grant selection: a holding lock owner wins unless its contended streak
    // has reached the cap, otherwise plain round-robin.
    always_comb begin
        w_own0_hold = (r_owner == OWN_P0) && req0 && lock0;
        w_own1_hold = (r_owner == OWN_P1) && req1 && lock1;
        w_cap       = (r_lock_cnt >= C_MAX_LOCK);
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (!resetn) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (w_own0_hold) begin
            if (req1 && w_cap) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else if (w_own1_hold) begin
            if (req0 && w_cap) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else if (req0 && req1) begin
            if (r_last) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else if (req0) begin
            w_gnt0 = 1'b1;
        end else if (req1) begin
            w_gnt1 = 1'b1;
        end
    end

    // Lock bookkeeping; the counter only advances when the other port waits.
    always_comb begin
        w_owner_nxt    = OWN_NONE;
        w_lock_cnt_nxt = '0;
        if (w_gnt0 && lock0) begin
            w_owner_nxt    = OWN_P0;
            w_lock_cnt_nxt = ((r_owner == OWN_P0) ? r_lock_cnt : '0)
                             + {{(C_CW-1){1'b0}}, req1};
        end else if (w_gnt1 && lock1) begin
            w_owner_nxt    = OWN_P1;
            w_lock_cnt_nxt = ((r_owner == OWN_P1) ? r_lock_cnt : '0)
                             + {{(C_CW-1){1'b0}}, req0};
        end
    end

    always_comb begin
        ram_a  = r_ram_a;
        ram_di = '0;
        ram_we = '0;
        if (w_gnt0) begin
            ram_a  = addr0;
            ram_di = wdata0;
            ram_we = we0;
        end else if (w_gnt1) begin
            ram_a  = addr1;
            ram_di = wdata1;
            ram_we = we1;
        end
        if (!resetn) begin
            ram_a = '0;
        end
    end

    assign ram_en  = w_gnt0 | w_gnt1;
    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    // Gating with resetn drops a read return already in flight when reset hits.
    assign rvalid0 = r_rvalid0 & resetn;
    assign rvalid1 = r_rvalid1 & resetn;
    assign rdata0  = ram_do;
    assign rdata1  = ram_do;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_owner    <= OWN_NONE;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            r_ram_a    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            if (ram_en) begin
                r_ram_a <= ram_a;
            end
            r_rvalid0 <= w_gnt0 & req0 & (we0 == 4'd0);
            r_rvalid1 <= w_gnt1 & req1 & (we1 == 4'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpga_ram_arbiter.sv
// ============================================================================
// Module   : tb_fpga_ram_arbiter
// Brief    : Self-checking bench for fpga_ram_arbiter with a RAM256 model,
//            directed scenarios and a randomized run against a reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpga_ram_arbiter;

    localparam int AW       = 8;
    localparam int MAX_LOCK = 8;

    logic          CLK = 1'b0;
    logic          resetn;
    logic          req0, req1, lock0, lock1;
    logic [3:0]    we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]   rdata0, rdata1;
    logic          ram_en;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [3:0]    ram_we;
    logic [31:0]   ram_do;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fpga_ram_arbiter #(.AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
        .CLK(CLK), .resetn(resetn),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_en(ram_en), .ram_a(ram_a), .ram_di(ram_di), .ram_we(ram_we),
        .ram_do(ram_do)
    );

    // RAM256 macro model: byte-enabled synchronous write, registered address.
    logic [31:0]   mem [256];
    logic [AW-1:0] mem_aq;
    logic          mem_clear;
    always @(posedge CLK) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem_aq <= '0;
        end else if (ram_en) begin
            mem_aq <= ram_a;
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end
    end
    assign ram_do = mem[mem_aq];

    // Reference model state
    logic [31:0]   shadow [256];
    int            m_last;
    int            m_owner;
    int            m_cnt;
    logic [1:0]    m_rv;
    logic [31:0]   m_rdexp [2];
    logic [AW-1:0] m_ra;

    function automatic logic p_req(input int p);
        return (p == 0) ? req0 : req1;
    endfunction
    function automatic logic p_lock(input int p);
        return (p == 0) ? lock0 : lock1;
    endfunction
    function automatic logic [3:0] p_we(input int p);
        return (p == 0) ? we0 : we1;
    endfunction
    function automatic logic [AW-1:0] p_addr(input int p);
        return (p == 0) ? addr0 : addr1;
    endfunction
    function automatic logic [31:0] p_wdata(input int p);
        return (p == 0) ? wdata0 : wdata1;
    endfunction

    // Who should win this cycle: -1 none, 0 or 1.
    function automatic int model_grant();
        if (!resetn) return -1;
        if (m_owner >= 0 && p_req(m_owner) && p_lock(m_owner)) begin
            if (p_req(1 - m_owner) && m_cnt >= MAX_LOCK) return 1 - m_owner;
            return m_owner;
        end
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int g);
        logic [3:0]    w;
        logic [31:0]   d, cur;
        logic [AW-1:0] a;
        if (!resetn) begin
            m_last = 1; m_owner = -1; m_cnt = 0; m_rv = 2'b00; m_ra = '0;
            return;
        end
        m_rv = 2'b00;
        if (g < 0) begin
            m_owner = -1; m_cnt = 0;
            return;
        end
        w = p_we(g); a = p_addr(g); d = p_wdata(g);
        if (w == 4'd0) begin
            m_rv[g]    = 1'b1;
            m_rdexp[g] = shadow[a];
        end else begin
            cur = shadow[a];
            for (int b = 0; b < 4; b++) if (w[b]) cur[8*b +: 8] = d[8*b +: 8];
            shadow[a] = cur;
        end
        m_ra = a;
        if (p_lock(g)) begin
            if (m_owner != g) m_cnt = 0;
            m_owner = g;
            if (p_req(1 - g)) m_cnt++;
        end else begin
            m_owner = -1; m_cnt = 0;
        end
        m_last = g;
    endtask

    task automatic advance(input int g);
        model_commit(g);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic reset_cycle();
        idle_inputs();
        resetn = 0;
        @(negedge CLK);
        advance(model_grant());
        resetn = 1;
    endtask

    task automatic test_reset();
        int g;
        idle_inputs();
        resetn = 0; req0 = 1; req1 = 1; addr0 = 8'h55; wdata0 = 32'h1234;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            g = model_grant();
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++; $display("FAIL rst_gnt: gnt0=%0b gnt1=%0b expected 0 0", gnt0, gnt1);
            end
            checks++;
            if (ram_en !== 1'b0 || ram_we !== 4'd0 || ram_a !== '0 || ram_di !== 32'd0) begin
                errors++; $display("FAIL rst_ram: en=%0b we=%0h a=%0h di=%0h expected all 0", ram_en, ram_we, ram_a, ram_di);
            end
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL rst_rvalid: %0b %0b expected 0 0", rvalid0, rvalid1);
            end
            advance(g);
        end
        idle_inputs();
        resetn = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            g = model_grant();
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 4'd0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL idle c=%0d: gnt=%0b%0b we=%0h rvalid=%0b%0b expected zeros", c, gnt0, gnt1, ram_we, rvalid0, rvalid1);
            end
            advance(g);
        end
    endtask

    task automatic test_write_read();
        int g;
        idle_inputs();
        req0 = 1; we0 = 4'hF; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_we !== 4'hF || ram_a !== 8'h10 || ram_di !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bus: gnt=%0b%0b we=%0h a=%0h di=%0h expected 10 f 10 deadbeef", gnt0, gnt1, ram_we, ram_a, ram_di);
        end
        advance(g);
        we0 = 4'h0;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt0 !== 1'b1 || ram_we !== 4'h0 || rvalid0 !== 1'b0) begin
            errors++; $display("FAIL rd_gnt: gnt0=%0b we=%0h rvalid0=%0b expected 1 0 0", gnt0, ram_we, rvalid0);
        end
        advance(g);
        req0 = 0;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL rd_data: rvalid0=%0b rdata0=%0h rvalid1=%0b expected 1 deadbeef 0", rvalid0, rdata0, rvalid1);
        end
        advance(g);
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (rvalid0 !== 1'b0 || ram_a !== 8'h10) begin
            errors++; $display("FAIL rd_once: rvalid0=%0b ram_a=%0h expected 0 10", rvalid0, ram_a);
        end
        advance(g);
    endtask

    task automatic test_partial_write();
        int g;
        idle_inputs();
        req1 = 1; we1 = 4'h1; addr1 = 8'h10; wdata1 = 32'h000000AA;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_we !== 4'h1 || ram_di !== 32'hAA) begin
            errors++; $display("FAIL pw_gnt: gnt=%0b%0b we=%0h di=%0h expected 01 1 aa", gnt0, gnt1, ram_we, ram_di);
        end
        advance(g);
        req1 = 0; req0 = 1; we0 = 4'h0; addr0 = 8'h10;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt0 !== 1'b1 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL pw_rd_gnt: gnt0=%0b rvalid1=%0b expected 1 0", gnt0, rvalid1);
        end
        advance(g);
        req0 = 0;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEAA) begin
            errors++; $display("FAIL pw_data: rvalid0=%0b rdata0=%0h expected 1 deadbeaa", rvalid0, rdata0);
        end
        advance(g);
    endtask

    task automatic test_round_robin();
        int g;
        reset_cycle();
        req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h11;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin req0 = 0; req1 = 0; end
            @(negedge CLK);
            g = model_grant();
            if (c < 6) begin
                checks++;
                if (gnt0 !== ((c % 2) == 0) || gnt1 !== ((c % 2) == 1)) begin
                    errors++; $display("FAIL rr_gnt c=%0d: gnt=%0b%0b expected port %0d", c, gnt0, gnt1, c % 2);
                end
            end
            if (c > 0) begin
                checks++;
                if (rvalid0 !== (((c - 1) % 2) == 0) || rvalid1 !== (((c - 1) % 2) == 1)) begin
                    errors++; $display("FAIL rr_rvalid c=%0d: rvalid=%0b%0b expected port %0d", c, rvalid0, rvalid1, (c - 1) % 2);
                end
                checks++;
                if ((c - 1) % 2 == 0 ? (rdata0 !== 32'hDEADBEAA) : (rdata1 !== 32'h0)) begin
                    errors++; $display("FAIL rr_rdata c=%0d: rdata0=%0h rdata1=%0h", c, rdata0, rdata1);
                end
            end
            advance(g);
        end
    endtask

    task automatic test_lock();
        int g;
        int exp_p [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        reset_cycle();
        req0 = 1; lock0 = 1; req1 = 1; addr0 = 8'h20; addr1 = 8'h21;
        for (int c = 0; c < 12; c++) begin
            lock0 = (c < 9);
            @(negedge CLK);
            g = model_grant();
            checks++;
            if (gnt0 !== (exp_p[c] == 0) || gnt1 !== (exp_p[c] == 1)) begin
                errors++; $display("FAIL lock_gnt c=%0d: gnt=%0b%0b expected port %0d", c, gnt0, gnt1, exp_p[c]);
            end
            advance(g);
        end
        idle_inputs();
    endtask

    task automatic test_same_addr();
        int g;
        reset_cycle();
        req0 = 1; we0 = 4'hF; addr0 = 8'h30; wdata0 = 32'h12345678;
        req1 = 1; we1 = 4'h0; addr1 = 8'h30;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL same_first: gnt=%0b%0b expected 10", gnt0, gnt1);
        end
        advance(g);
        req0 = 0;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin
            errors++; $display("FAIL same_second: gnt1=%0b rvalid0=%0b expected 1 0", gnt1, rvalid0);
        end
        advance(g);
        req1 = 0;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678) begin
            errors++; $display("FAIL same_data: rvalid1=%0b rdata1=%0h expected 1 12345678", rvalid1, rdata1);
        end
        advance(g);
    endtask

    task automatic test_reset_mid();
        int g;
        reset_cycle();
        req1 = 1; we1 = 4'h0; addr1 = 8'h30;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++; $display("FAIL rm_gnt1: gnt1=%0b expected 1", gnt1);
        end
        advance(g);
        resetn = 0; req0 = 1; req1 = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            g = model_grant();
            checks++;
            if (rvalid1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++; $display("FAIL rm_suppress c=%0d: rvalid1=%0b gnt=%0b%0b expected 0 00", c, rvalid1, gnt0, gnt1);
            end
            advance(g);
        end
        resetn = 1;
        @(negedge CLK);
        g = model_grant();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL rm_first: gnt=%0b%0b rvalid1=%0b expected 10 0", gnt0, gnt1, rvalid1);
        end
        advance(g);
        idle_inputs();
    endtask

    task automatic test_random(input int ncyc);
        int          g;
        int          prev_g;
        logic [3:0]  exp_we;
        logic [AW-1:0] exp_a;
        prev_g = -1;
        for (int c = 0; c < ncyc; c++) begin
            resetn = ($urandom_range(0, 59) != 0);
            if (!(req0 && prev_g != 0)) begin
                req0   = ($urandom_range(0, 3) != 0);
                we0    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                addr0  = AW'($urandom_range(0, 7));
                wdata0 = $urandom;
            end
            if (!(req1 && prev_g != 1)) begin
                req1   = ($urandom_range(0, 3) != 0);
                we1    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                addr1  = AW'($urandom_range(0, 7));
                wdata1 = $urandom;
            end
            lock0 = ($urandom_range(0, 3) != 0);
            lock1 = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            g = model_grant();
            exp_we = (g >= 0) ? p_we(g) : 4'h0;
            exp_a  = !resetn ? '0 : ((g >= 0) ? p_addr(g) : m_ra);
            checks++;
            if (gnt0 !== (g == 0) || gnt1 !== (g == 1) || ram_en !== (g >= 0)) begin
                errors++; $display("FAIL rnd_gnt c=%0d: gnt=%0b%0b en=%0b expected winner %0d", c, gnt0, gnt1, ram_en, g);
            end
            checks++;
            if (ram_we !== exp_we || ram_a !== exp_a) begin
                errors++; $display("FAIL rnd_bus c=%0d: we=%0h a=%0h expected %0h %0h", c, ram_we, ram_a, exp_we, exp_a);
            end
            if (g >= 0) begin
                checks++;
                if (ram_di !== p_wdata(g)) begin
                    errors++; $display("FAIL rnd_di c=%0d: di=%0h expected %0h", c, ram_di, p_wdata(g));
                end
            end
            checks++;
            if (rvalid0 !== (resetn & m_rv[0]) || rvalid1 !== (resetn & m_rv[1])) begin
                errors++; $display("FAIL rnd_rvalid c=%0d: rvalid=%0b%0b expected %0b%0b", c, rvalid0, rvalid1, resetn & m_rv[0], resetn & m_rv[1]);
            end
            if (resetn && m_rv[0]) begin
                checks++;
                if (rdata0 !== m_rdexp[0]) begin
                    errors++; $display("FAIL rnd_rdata0 c=%0d: rdata0=%0h expected %0h", c, rdata0, m_rdexp[0]);
                end
            end
            if (resetn && m_rv[1]) begin
                checks++;
                if (rdata1 !== m_rdexp[1]) begin
                    errors++; $display("FAIL rnd_rdata1 c=%0d: rdata1=%0h expected %0h", c, rdata1, m_rdexp[1]);
                end
            end
            advance(g);
            prev_g = g;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        m_rdexp[0] = '0;
        m_rdexp[1] = '0;
        idle_inputs();
        resetn = 0;
        m_last = 1; m_owner = -1; m_cnt = 0; m_rv = 2'b00; m_ra = '0;
        mem_clear = 1;
        @(posedge CLK);
        #1;
        mem_clear = 0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_round_robin();
        test_lock();
        test_same_addr();
        test_reset_mid();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
